shift_sub_divider: RTL and testbench

//  Sequential unsigned restoring divider: Q = Q / Din, R = Q mod Din.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_sub_unit.sv | 24 ++
 rtl/shift_sub_divider.sv | 131 +++++++++++++
 tb/tb_shift_sub_divider.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_pkg
// Brief   : Shared state type and default width for the shift/subtract divider
// Revision: 1.0  initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SUB   = 2'd2,
        HOLD  = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_sub_unit.sv
`default_nettype none
// ============================================================================
// Module  : div_sub_unit
// Brief   : Trial subtraction of the divisor from the partial remainder
// Revision: 1.0  initial release
// ============================================================================
module div_sub_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_pr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH:0]   o_diff,
    output logic             o_borrow
);

    // One guard bit above the partial remainder catches the borrow.
    logic [WIDTH+1:0] w_diff;

    assign w_diff   = {1'b0, i_pr} - {2'b00, i_d};
    assign o_diff   = w_diff[WIDTH:0];
    assign o_borrow = w_diff[WIDTH+1];

endmodule : div_sub_unit
`default_nettype wire

// File: rtl/shift_sub_divider.sv
`default_nettype none
// ============================================================================
// Module  : shift_sub_divider
// Brief   : Button-driven sequential unsigned restoring divider (Q / Din)
// Revision: 1.0  initial release
// ============================================================================
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ClearR_LoadQ,
    input  logic             Run,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       r_state, w_state;
    logic [WIDTH-1:0] r_q, w_q;
    logic [WIDTH-1:0] r_d, w_d;
    logic [WIDTH:0]   r_pr, w_pr;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_divzero, w_divzero;

    logic [WIDTH:0]   w_sub_diff;
    logic             w_sub_borrow;

    div_sub_unit #(
        .WIDTH (WIDTH)
    ) u_sub (
        .i_pr     (r_pr),
        .i_d      (r_d),
        .o_diff   (w_sub_diff),
        .o_borrow (w_sub_borrow)
    );

    always_comb begin
        w_state   = r_state;
        w_q       = r_q;
        w_d       = r_d;
        w_pr      = r_pr;
        w_cnt     = r_cnt;
        w_divzero = r_divzero;

        case (r_state)
            IDLE: begin
                if (ClearR_LoadQ) begin
                    w_q       = Din;
                    w_pr      = '0;
                    w_divzero = 1'b0;
                end else if (Run) begin
                    w_d       = Din;
                    w_pr      = '0;
                    w_cnt     = '0;
                    w_divzero = 1'b0;
                    if (Din != '0) begin
                        w_state = SHIFT;
                    end else begin
                        // Divide by zero: saturate quotient, dividend lands in R.
                        w_q       = '1;
                        w_pr      = {1'b0, r_q};
                        w_divzero = 1'b1;
                        w_state   = HOLD;
                    end
                end
            end
            SHIFT: begin
                w_pr    = {r_pr[WIDTH-1:0], r_q[WIDTH-1]};
                w_q     = {r_q[WIDTH-2:0], 1'b0};
                w_state = SUB;
            end
            SUB: begin
                if (!w_sub_borrow) begin
                    w_pr   = w_sub_diff;
                    w_q[0] = 1'b1;
                end
                if (r_cnt == c_LAST_CNT) begin
                    w_state = HOLD;
                end else begin
                    w_cnt   = r_cnt + CNT_W'(1);
                    w_state = SHIFT;
                end
            end
            HOLD: begin
                if (ClearR_LoadQ) begin
                    w_q       = Din;
                    w_pr      = '0;
                    w_divzero = 1'b0;
                end else if (!Run) begin
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_q       <= '0;
            r_d       <= '0;
            r_pr      <= '0;
            r_cnt     <= '0;
            r_divzero <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_q       <= w_q;
            r_d       <= w_d;
            r_pr      <= w_pr;
            r_cnt     <= w_cnt;
            r_divzero <= w_divzero;
        end
    end

    assign Q       = r_q;
    assign R       = r_pr[WIDTH-1:0];
    assign Busy    = (r_state == SHIFT) || (r_state == SUB);
    assign Done    = (r_state == HOLD);
    assign DivZero = r_divzero;

endmodule : shift_sub_divider
`default_nettype wire

// File: tb/tb_shift_sub_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_shift_sub_divider
// Brief   : Self-checking bench for shift_sub_divider (vectors + random model)
// Revision: 1.0  initial release
// ============================================================================
module tb_shift_sub_divider;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         ClearR_LoadQ;
    logic         Run;
    logic [W-1:0] Din;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         Busy;
    logic         Done;
    logic         DivZero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs [6];

    always #5 Clk = ~Clk;

    shift_sub_divider #(
        .WIDTH (W)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ClearR_LoadQ (ClearR_LoadQ),
        .Run          (Run),
        .Din          (Din),
        .Q            (Q),
        .R            (R),
        .Busy         (Busy),
        .Done         (Done),
        .DivZero      (DivZero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Optionally reload the dividend, then start with divisor b and wait for Done.
    // Run is left high on return; Din is scrambled while busy to prove D was captured.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit reload,
                           output int lat, output int busy_cnt);
        if (reload) begin
            ClearR_LoadQ = 1'b1;
            Din          = a;
            @(negedge Clk);
            ClearR_LoadQ = 1'b0;
        end
        Run      = 1'b1;
        Din      = b;
        lat      = 0;
        busy_cnt = 0;
        do begin
            @(negedge Clk);
            lat++;
            if (Busy) busy_cnt++;
            Din = W'($urandom);
        end while (!Done && lat < 100);
    endtask

    task automatic release_run();
        Run = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        int lat, bc;
        logic [W-1:0] m_q, m_r, a, b;
        logic         m_dz;
        bit           ok;

        vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,  dz: 1'b0};
        vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0};
        vecs[2] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0};
        vecs[3] = '{a: 8'd255, b: 8'd200, q: 8'd1,   r: 8'd55, dz: 1'b0};
        vecs[4] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0};
        vecs[5] = '{a: 8'd42,  b: 8'd0,   q: 8'hFF,  r: 8'd42, dz: 1'b1};

        Reset = 1'b1; ClearR_LoadQ = 1'b0; Run = 1'b0; Din = '0;
        @(negedge Clk);
        @(negedge Clk);
        check("reset_Q", Q, 0);
        check("reset_R", R, 0);
        check("reset_flags", {Busy, Done, DivZero}, 0);
        Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 6; i++) begin
            run_div(vecs[i].a, vecs[i].b, 1'b1, lat, bc);
            check($sformatf("vec%0d_Q", i), Q, vecs[i].q);
            check($sformatf("vec%0d_R", i), R, vecs[i].r);
            check($sformatf("vec%0d_dz", i), DivZero, vecs[i].dz);
            check($sformatf("vec%0d_latency", i), lat, (vecs[i].b != 0) ? 2 * W + 1 : 1);
            check($sformatf("vec%0d_busy", i), bc, (vecs[i].b != 0) ? 2 * W : 0);
            release_run();
        end

        // Load in HOLD after a divide-by-zero clears the flag and stays in HOLD.
        run_div(8'd42, 8'd0, 1'b1, lat, bc);
        ClearR_LoadQ = 1'b1;
        Din          = 8'd77;
        @(negedge Clk);
        ClearR_LoadQ = 1'b0;
        check("hold_load_Q", Q, 77);
        check("hold_load_R", R, 0);
        check("hold_load_dz_done", {DivZero, Done}, 2'b01);
        release_run();

        // Run held after Done must not restart; then chain 14 / 7.
        run_div(8'd100, 8'd7, 1'b1, lat, bc);
        ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (!Done || Busy || Q != 8'd14) ok = 1'b0;
        end
        check("run_held_no_restart", ok, 1);
        release_run();
        check("released_idle", {Busy, Done}, 0);
        run_div(8'd0, 8'd7, 1'b0, lat, bc);
        check("chain_Q", Q, 2);
        check("chain_R", R, 0);
        release_run();

        // Reset during the third SUB step aborts everything.
        ClearR_LoadQ = 1'b1; Din = 8'd100;
        @(negedge Clk);
        ClearR_LoadQ = 1'b0; Run = 1'b1; Din = 8'd7;
        for (int k = 0; k < 6; k++) @(negedge Clk);
        check("mid_op_busy", Busy, 1);
        Reset = 1'b1; Run = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        check("abort_Q", Q, 0);
        check("abort_R", R, 0);
        check("abort_flags", {Busy, Done, DivZero}, 0);
        run_div(8'd100, 8'd7, 1'b1, lat, bc);
        check("after_abort_Q", Q, 14);
        check("after_abort_R", R, 2);
        release_run();

        // Load beats Run in IDLE.
        ClearR_LoadQ = 1'b1; Run = 1'b1; Din = 8'd9;
        @(negedge Clk);
        ClearR_LoadQ = 1'b0; Run = 1'b0;
        check("load_prio_Q", Q, 9);
        check("load_prio_busy", Busy, 0);
        @(negedge Clk);
        check("load_prio_still_idle", {Busy, Done}, 0);

        // Load request during SUB is ignored.
        ClearR_LoadQ = 1'b1; Din = 8'd100;
        @(negedge Clk);
        ClearR_LoadQ = 1'b0; Run = 1'b1; Din = 8'd7;
        @(negedge Clk);
        @(negedge Clk);
        ClearR_LoadQ = 1'b1; Din = 8'd55;
        @(negedge Clk);
        ClearR_LoadQ = 1'b0;
        lat = 0;
        while (!Done && lat < 100) begin
            @(negedge Clk);
            lat++;
        end
        check("sub_load_ignored_Q", Q, 14);
        check("sub_load_ignored_R", R, 2);
        release_run();

        // Random operations with occasional chaining against a plain arithmetic model.
        m_q = 8'd14;
        for (int i = 0; i < 40; i++) begin
            bit reload;
            reload = (i % 4) != 3;
            a = reload ? W'($urandom) : m_q;
            b = ($urandom_range(0, 9) == 0) ? 8'd0 : W'($urandom);
            if (b == 0) begin
                m_q = 8'hFF; m_r = a; m_dz = 1'b1;
            end else begin
                m_q = a / b; m_r = a % b; m_dz = 1'b0;
            end
            run_div(a, b, reload, lat, bc);
            check($sformatf("rnd%0d_Q %0d/%0d", i, a, b), Q, m_q);
            check($sformatf("rnd%0d_R %0d/%0d", i, a, b), R, m_r);
            check($sformatf("rnd%0d_dz", i), DivZero, m_dz);
            release_run();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shift_sub_divider
`default_nettype wire
